pixel_readout_buffer: RTL and testbench
=======================================

# pixel_readout_buffer

Downstream stage of the pixel array: captures the four 8-bit pixel buses when the array FSM enters its read phase, stores each capture as one frame in a small frame FIFO, and serializes frames out byte by byte over a valid/ready stream. It decouples the fixed-timing pixel readout from a slower or stalling consumer, such as a link or memory writer. It also reports dropped frames.

## Interface
- DEPTH, 2: FIFO capacity in frames (one frame = 4 pixels = 32 bits); power of two, at least 2.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- read  in  1  read-phase strobe from the pixel array FSM; held high for one or more cycles per frame.
- pixData1..pixData4  in  8 each  pixel buses, driven by the array while read=1.
- dout  out  8  current output pixel byte.
- dout_valid  out  1  dout holds a valid byte.
- dout_ready  in  1  consumer accepts; transfer = dout_valid & dout_ready at a rising edge.
- dout_first  out  1  high with pixel 0 (pixData1) of a frame.
- dout_last  out  1  high with pixel 3 (pixData4) of a frame.
- overflow  out  1  sticky; a frame was dropped.
- ovf_clear  in  1  synchronous clear of overflow and drop_count.
- drop_count  out  8  number of dropped frames; saturates at 255.

## Operation
- Edge detector: register read_q. The capture condition is read=1 & read_q=0, sampled at a rising edge.
- Only one capture occurs per read pulse, regardless of pulse length. A read held high across reset release captures once, because read_q resets to 0.
- On capture, the frame {pixData4, pixData3, pixData2, pixData1} is pushed as one 32-bit entry if count < DEPTH. Count is evaluated before the edge.
- If count = DEPTH, the frame is dropped whole. overflow is set to 1 and drop_count increments, saturating at 255. A pop in the same cycle does not rescue the frame.
- FIFO: write pointer, read pointer, and count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH. A simultaneous push and pop leaves count unchanged.
- Serializer:
  - A 2-bit byte index idx selects a byte of the head entry: idx 0 selects pixData1, through idx 3 selecting pixData4.
  - dout = selected byte; dout_valid = (count ≠ 0).
  - dout_first = valid & idx=0; dout_last = valid & idx=3.
- On a transfer, idx increments. A transfer with idx=3 pops the head and sets idx to 0.
- While dout_valid=1 and dout_ready=0, dout, dout_first, dout_last and idx hold stable.
- ovf_clear=1 clears overflow and drop_count at the next edge. A drop in the same cycle takes priority: overflow=1 and drop_count=1.
- Reset values: dout_valid=0, dout_first=0, dout_last=0, overflow=0, drop_count=0, count=0, pointers=0, idx=0, read_q=0. dout is 0 (empty FIFO storage reads as don't-care, but is reset to 0).
- Reset asserted mid-frame discards all buffered and partially sent frames. No partial frame is resumed.

## Timing
- Capture at edge E: dout_valid=1 and dout=pixData1 value become visible after edge E, in the cycle following E.
- With dout_ready held at 1, one byte transfers per cycle. A frame takes 4 cycles, and back-to-back frames stream with no bubble.
- Latency from read rise to pixel 3 accepted is a minimum of 4 edges after E.
- Push and pop are single-cycle. Full and empty decisions use registered count only, with no combinational path from read to dout_ready.
- No combinational path from dout_ready to dout_valid.

## Test plan
- Single frame: reset, pixData1..4 = 0x11,0x22,0x33,0x44, read high for 3 cycles, dout_ready=1.
  - Required: exactly 4 bytes 0x11,0x22,0x33,0x44; first on 0x11, last on 0x44; then dout_valid=0.
- Backpressure: same frame, dout_ready=0 for 5 cycles, then toggling 1/0.
  - Required: dout holds 0x11 while stalled, and no byte is lost or duplicated.
- Overflow: DEPTH=2, dout_ready=0, three read pulses with frames A, B, C.
  - Required: overflow=1 and drop_count=1 after the third pulse.
  - Required: after enabling dout_ready, only A then B are output (8 bytes).
- Wrap and concurrency: dout_ready=1, read pulses every 4 cycles for 20 frames with incrementing data.
  - Required: all 80 bytes in order, drop_count=0, count never exceeds 2.
- Clear and saturation: force 300 drops.
  - Required: drop_count=255; ovf_clear pulse sets overflow=0 and drop_count=0.
  - Required: ovf_clear coincident with a drop gives overflow=1 and drop_count=1.
- Reset mid-frame: assert reset low after 2 bytes are sent.
  - Required: dout_valid=0 immediately; after release, with no new read pulse, nothing is output.

Source files
------------

// File: rtl/pixel_readout_buffer.sv
// Captures one 4-pixel frame per read pulse into a small frame FIFO and
// streams the head frame out byte by byte on a valid/ready interface.
module pixel_readout_buffer #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read,
    input  logic [7:0] pixData1,
    input  logic [7:0] pixData2,
    input  logic [7:0] pixData3,
    input  logic [7:0] pixData4,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_first,
    output logic       dout_last,
    output logic       overflow,
    input  logic       ovf_clear,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    idx;
    logic          read_q;

    logic capture;
    logic full;
    logic push;
    logic drop;
    logic xfer;
    logic pop;

    function automatic logic [7:0] sel_byte(input logic [31:0] frame, input logic [1:0] sel);
        case (sel)
            2'd0:    sel_byte = frame[7:0];
            2'd1:    sel_byte = frame[15:8];
            2'd2:    sel_byte = frame[23:16];
            default: sel_byte = frame[31:24];
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Full/empty come from the registered count only, so read never reaches dout_ready.
    assign capture = read & ~read_q;
    assign full    = (count == CW'(DEPTH));
    assign push    = capture & ~full;
    assign drop    = capture & full;
    assign xfer    = dout_valid & dout_ready;
    assign pop     = xfer & (idx == 2'd3);

    assign dout_valid = (count != '0);
    assign dout_first = dout_valid & (idx == 2'd0);
    assign dout_last  = dout_valid & (idx == 2'd3);
    assign dout       = dout_valid ? sel_byte(mem[rd_ptr], idx) : 8'h00;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pixData4, pixData3, pixData2, pixData1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            idx        <= 2'd0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            read_q <= read;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (xfer) begin
                idx <= idx + 2'd1;
            end

            // A drop wins over a coincident clear: that drop is the first of a new tally.
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= ovf_clear ? 8'd1 : sat_inc(drop_count);
            end else if (ovf_clear) begin
                overflow   <= 1'b0;
                drop_count <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed bench for pixel_readout_buffer: single frame, backpressure, overflow,
// wrap, drop-count saturation/clear and mid-frame reset.
module tb_pixel_readout_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       read;
    logic [7:0] pixData1, pixData2, pixData3, pixData4;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_first;
    logic       dout_last;
    logic       overflow;
    logic       ovf_clear;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;
    logic [9:0] q[$];
    int max_count = 0;

    always #5 clk = ~clk;

    pixel_readout_buffer #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .read(read),
        .pixData1(pixData1), .pixData2(pixData2), .pixData3(pixData3), .pixData4(pixData4),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_first(dout_first), .dout_last(dout_last),
        .overflow(overflow), .ovf_clear(ovf_clear), .drop_count(drop_count)
    );

    // Record every byte that will transfer at the coming rising edge.
    always @(negedge clk) begin
        if (reset && dout_valid && dout_ready) q.push_back({dout_first, dout_last, dout});
        if (int'(dut.count) > max_count) max_count = int'(dut.count);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pix(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        pixData1 = a; pixData2 = b; pixData3 = c; pixData4 = d;
    endtask

    task automatic pulse_read();
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp_b [4];
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        for (int i = 0; i < 4; i++) begin
            if (base + i < q.size())
                check($sformatf("%s_b%0d", tag, i), {22'd0, q[base+i]},
                      {22'd0, (i == 0), (i == 3), exp_b[i]});
            else
                check($sformatf("%s_b%0d_missing", tag, i), 32'(q.size()), 32'(base + i + 1));
        end
    endtask

    initial begin
        reset = 1'b0; read = 1'b0; dout_ready = 1'b0; ovf_clear = 1'b0;
        set_pix(8'h00, 8'h00, 8'h00, 8'h00);
        tick(2);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_first_last", {30'd0, dout_first, dout_last}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_drops", {24'd0, drop_count}, 32'd0);
        reset = 1'b1;
        tick();

        // Single frame, read held 3 cycles
        set_pix(8'h11, 8'h22, 8'h33, 8'h44);
        dout_ready = 1'b1;
        read = 1'b1;
        tick(3);
        read = 1'b0;
        tick(8);
        check("single_count", 32'(q.size()), 32'd4);
        check_frame("single", 0, 8'h11, 8'h22, 8'h33, 8'h44);
        check("single_idle", {31'd0, dout_valid}, 32'd0);
        q.delete();

        // Backpressure: stall then toggle ready
        dout_ready = 1'b0;
        pulse_read();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_dout%0d", i), {24'd0, dout}, 32'h11);
            check($sformatf("stall_first%0d", i), {31'd0, dout_first}, 32'd1);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            dout_ready = ~dout_ready;
            tick();
        end
        dout_ready = 1'b1;
        tick(6);
        check("bp_count", 32'(q.size()), 32'd4);
        check_frame("bp", 0, 8'h11, 8'h22, 8'h33, 8'h44);
        q.delete();

        // Overflow: three frames into a 2-deep FIFO with the consumer stalled
        dout_ready = 1'b0;
        set_pix(8'hA0, 8'hA1, 8'hA2, 8'hA3); pulse_read();
        set_pix(8'hB0, 8'hB1, 8'hB2, 8'hB3); pulse_read();
        check("ovf_before", {31'd0, overflow}, 32'd0);
        set_pix(8'hC0, 8'hC1, 8'hC2, 8'hC3); pulse_read();
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_drops", {24'd0, drop_count}, 32'd1);
        dout_ready = 1'b1;
        tick(12);
        check("ovf_out_count", 32'(q.size()), 32'd8);
        check_frame("ovf_A", 0, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        check_frame("ovf_B", 4, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
        q.delete();
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Wrap and concurrency: a new frame every 4 cycles
        max_count = 0;
        for (int f = 0; f < 20; f++) begin
            set_pix(8'(4*f+1), 8'(4*f+2), 8'(4*f+3), 8'(4*f+4));
            read = 1'b1;
            tick();
            read = 1'b0;
            tick(3);
        end
        tick(8);
        check("wrap_count", 32'(q.size()), 32'd80);
        for (int f = 0; f < 20; f++)
            check_frame($sformatf("wrap_f%0d", f), 4*f, 8'(4*f+1), 8'(4*f+2), 8'(4*f+3), 8'(4*f+4));
        check("wrap_drops", {24'd0, drop_count}, 32'd0);
        check("wrap_max_count_le2", {31'd0, (max_count <= 2)}, 32'd1);
        q.delete();

        // Saturation: fill, then 300 drops
        dout_ready = 1'b0;
        set_pix(8'h55, 8'h66, 8'h77, 8'h88);
        pulse_read();
        pulse_read();
        for (int i = 0; i < 300; i++) pulse_read();
        check("sat_drops", {24'd0, drop_count}, 32'd255);
        check("sat_ovf", {31'd0, overflow}, 32'd1);
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_drops", {24'd0, drop_count}, 32'd0);
        read = 1'b1; ovf_clear = 1'b1;
        tick();
        read = 1'b0; ovf_clear = 1'b0;
        check("clr_drop_ovf", {31'd0, overflow}, 32'd1);
        check("clr_drop_drops", {24'd0, drop_count}, 32'd1);
        tick();
        dout_ready = 1'b1;
        tick(12);
        q.delete();

        // Reset mid-frame after two bytes
        dout_ready = 1'b0;
        set_pix(8'h11, 8'h22, 8'h33, 8'h44);
        pulse_read();
        dout_ready = 1'b1;
        tick(2);
        dout_ready = 1'b0;
        check("mid_sent", 32'(q.size()), 32'd2);
        check("mid_next_byte", {24'd0, dout}, 32'h33);
        q.delete();
        #1 reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        tick(2);
        reset = 1'b1;
        dout_ready = 1'b1;
        tick(10);
        check("mid_after_out", 32'(q.size()), 32'd0);
        check("mid_after_valid", {31'd0, dout_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
